// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with valid/ready handshake.
//
// Carries PC, instruction, control word, data, register-A operand and destination
// index from one stage to the next. SKID=1 builds a 2-entry elastic stage (output
// register plus skid register) whose in_ready_o comes straight from a flop, so there
// is no combinational path from out_ready_i back upstream. SKID=0 builds a single
// register with in_ready_o = !out_valid_o | out_ready_i.
//
// Ports:
//   clk_i            rising-edge clock
//   clr_ni           asynchronous active-low reset
//   flush_i          synchronous flush: drop contents, next cycle is a bubble
//   in_valid_i       upstream offers a beat
//   in_ready_o       stage can accept a beat this cycle
//   in_*_i           upstream payload fields
//   out_valid_o      out_*_o holds a valid beat
//   out_ready_i      downstream accepts the beat
//   out_*_o          registered payload fields, all zero whenever out_valid_o=0
//   stall_cnt_o      saturating count of cycles with out_valid_o & !out_ready_i

module pipe_stage_reg #(
    parameter int unsigned PC_W    = 16,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned CW_W    = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RA_W    = 16,
    parameter int unsigned DEST_W  = 3,
    parameter bit          SKID    = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               clr_ni,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [PC_W-1:0]    in_pc_i,
    input  logic [INSTR_W-1:0] in_instr_i,
    input  logic [CW_W-1:0]    in_cw_i,
    input  logic [DATA_W-1:0]  in_data_i,
    input  logic [RA_W-1:0]    in_ra_i,
    input  logic [DEST_W-1:0]  in_dest_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [PC_W-1:0]    out_pc_o,
    output logic [INSTR_W-1:0] out_instr_o,
    output logic [CW_W-1:0]    out_cw_o,
    output logic [DATA_W-1:0]  out_data_o,
    output logic [RA_W-1:0]    out_ra_o,
    output logic [DEST_W-1:0]  out_dest_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    localparam int unsigned PW = PC_W + INSTR_W + CW_W + DATA_W + RA_W + DEST_W;

    logic [PW-1:0] in_beat;
    logic [PW-1:0] out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic          accept, pop;

    assign in_beat = {in_pc_i, in_instr_i, in_cw_i, in_data_i, in_ra_i, in_dest_i};
    assign accept  = in_valid_i & in_ready_o;
    assign pop     = out_valid_q & out_ready_i;

    if (SKID) begin : g_skid
        typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

        state_e        st_q, st_d;
        logic [PW-1:0] skid_q, skid_d;
        logic          in_ready_q, in_ready_d;

        always_comb begin
            st_d        = st_q;
            skid_d      = skid_q;
            out_d       = out_q;
            out_valid_d = out_valid_q;
            if (flush_i) begin
                // A pop this cycle has already been taken downstream; nothing to keep.
                st_d        = StEmpty;
                skid_d      = '0;
                out_d       = '0;
                out_valid_d = 1'b0;
            end else begin
                case (st_q)
                    StEmpty: begin
                        if (accept) begin
                            out_d       = in_beat;
                            out_valid_d = 1'b1;
                            st_d        = StOne;
                        end
                    end
                    StOne: begin
                        if (accept && pop) begin
                            out_d = in_beat;
                        end else if (accept) begin
                            skid_d = in_beat;
                            st_d   = StTwo;
                        end else if (pop) begin
                            out_d       = '0;
                            out_valid_d = 1'b0;
                            st_d        = StEmpty;
                        end
                    end
                    StTwo: begin
                        // in_ready_o is low here, so only a pop can happen.
                        if (pop) begin
                            out_d  = skid_q;
                            skid_d = '0;
                            st_d   = StOne;
                        end
                    end
                    default: begin
                        st_d        = StEmpty;
                        skid_d      = '0;
                        out_d       = '0;
                        out_valid_d = 1'b0;
                    end
                endcase
            end
            in_ready_d = (st_d != StTwo);
        end

        always_ff @(posedge clk_i or negedge clr_ni) begin
            if (!clr_ni) begin
                st_q       <= StEmpty;
                skid_q     <= '0;
                in_ready_q <= 1'b1;
            end else begin
                st_q       <= st_d;
                skid_q     <= skid_d;
                in_ready_q <= in_ready_d;
            end
        end

        assign in_ready_o = in_ready_q;
    end else begin : g_noskid
        assign in_ready_o = ~out_valid_q | out_ready_i;

        always_comb begin
            out_d       = out_q;
            out_valid_d = out_valid_q;
            if (flush_i) begin
                out_d       = '0;
                out_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = in_beat;
                out_valid_d = 1'b1;
            end else if (pop) begin
                out_d       = '0;
                out_valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready_i && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign {out_pc_o, out_instr_o, out_cw_o, out_data_o, out_ra_o, out_dest_o} = out_q;
    assign stall_cnt_o = stall_q;

endmodule
